// File: rtl/drv_segment_scan.sv
// -----------------------------------------------------------------------------
// drv_segment_scan
//
// Time-multiplexed scan driver for a common-anode BCD 7-segment display.
// Each digit owns a slot of DIV clock cycles. The first DEAD cycles of a slot
// are dark, to keep the previous digit from ghosting into the new one. The
// remaining cycles light the digit unless it is blank. Display data comes
// from shadow registers that are loaded by a single-cycle strobe.
//
// Optional feature:
//   DRV_SEGMENT_SCAN_LZB_EN - when defined, digits above the most significant
//                             nonzero nibble are blanked. Digit 0 is always
//                             shown.
//
// Parameters:
//   DIGITS - number of multiplexed digits (1..8)
//   DIV    - clock cycles per digit slot (>= 2)
//   DEAD   - dark cycles at the start of each slot (0 <= DEAD < DIV)
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_val    - packed BCD values, nibble k drives digit k
//   i_load   - strobe that captures i_val / i_blank into the shadow registers
//   i_blank  - per-digit forced blank
//   o_val    - nibble for the downstream decoder; 4'hF means blank
//   o_anode  - active-low digit enables, at most one bit low
//   o_idx    - index of the digit currently being scanned
// -----------------------------------------------------------------------------
module drv_segment_scan #(
   parameter int DIGITS = 8,
   parameter int DIV    = 100000,
   parameter int DEAD   = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [4*DIGITS-1:0]   i_val,
   input  logic                  i_load,
   input  logic [DIGITS-1:0]     i_blank,
   output logic [3:0]            o_val,
   output logic [DIGITS-1:0]     o_anode,
   output logic [2:0]            o_idx
);

   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   typedef enum logic {
      ST_DARK,
      ST_LIT
   } state_t;

   // With no dead time the slot opens lit.
   localparam state_t START_STATE = (DEAD > 0) ? ST_DARK : ST_LIT;

   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_next;
   logic                  cnt_last;
   logic [2:0]            idx;
   logic [2:0]            idx_next;
   logic                  lit_next;
   state_t                state;

   logic [4*DIGITS-1:0]   sh_val;
   logic [DIGITS-1:0]     sh_blk;

   // Shadow data padded to eight digits so it can be indexed by the 3-bit
   // digit index for any DIGITS. Padding digits are zero-valued and blank.
   logic [31:0]           val_pad;
   logic [7:0]            blk_pad;
   logic [7:0]            digit_blank;
   logic [3:0]            nib;
   logic [3:0]            cur_nib;
   logic [7:0]            sel_onehot;
`ifdef DRV_SEGMENT_SCAN_LZB_EN
   logic                  higher_zero;
`endif

   // ---------------------------------------------------------------------------
   // Slot timing
   // ---------------------------------------------------------------------------
   assign cnt_last = (cnt == CNT_W'(DIV - 1));
   assign cnt_next = cnt_last ? '0 : cnt + CNT_W'(1);
   assign idx_next = !cnt_last ? idx :
                     (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
   // Signed compare keeps DEAD = 0 well defined: the slot is then always lit.
   assign lit_next = (int'(cnt_next) >= DEAD);

   // ---------------------------------------------------------------------------
   // Per-digit blanking
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any conditional or loop
      // assignment, so no latch is inferred; blocking '=' is correct here
      // because later lines read the values computed by earlier ones.
      val_pad                   = '0;
      val_pad[4*DIGITS-1:0]     = sh_val;
      blk_pad                   = '1;
      blk_pad[DIGITS-1:0]       = sh_blk;
      digit_blank               = '1;
      nib                       = 4'd0;
`ifdef DRV_SEGMENT_SCAN_LZB_EN
      higher_zero               = 1'b1;
`endif
      // Walk from the top digit down so leading-zero state accumulates.
      for (int k = 7; k >= 0; k--) begin
         nib = val_pad[4*k +: 4];
`ifdef DRV_SEGMENT_SCAN_LZB_EN
         higher_zero    = higher_zero && (nib == 4'd0);
         digit_blank[k] = blk_pad[k] || (nib > 4'd9) || (higher_zero && (k != 0));
`else
         digit_blank[k] = blk_pad[k] || (nib > 4'd9);
`endif
      end
   end

   assign cur_nib    = val_pad[{idx, 2'b00} +: 4];
   assign sel_onehot = 8'b1 << idx;

   // ---------------------------------------------------------------------------
   // Scan FSM, shadow registers and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt     <= '0;
         idx     <= 3'd0;
         state   <= START_STATE;
         sh_val  <= '0;
         // Shadow blank resets to all ones: nothing lights until first load.
         sh_blk  <= '1;
         o_anode <= '1;
         o_val   <= 4'hF;
         o_idx   <= 3'd0;
      end else begin
         // NOTE: sequential state uses non-blocking '<=' so every register
         // samples the pre-edge values, independent of statement order.
         cnt   <= cnt_next;
         idx   <= idx_next;
         state <= lit_next ? ST_LIT : ST_DARK;

         if (i_load) begin
            sh_val <= i_val;
            sh_blk <= i_blank;
         end

         // Outputs reflect the current (pre-edge) slot state: 1-cycle latency.
         if ((state == ST_LIT) && !digit_blank[idx]) begin
            o_anode <= ~sel_onehot[DIGITS-1:0];
            o_val   <= cur_nib;
         end else begin
            o_anode <= '1;
            o_val   <= 4'hF;
         end
         o_idx <= idx;
      end
   end

endmodule

// File: tb/tb_drv_segment_scan.sv
// -----------------------------------------------------------------------------
// tb_drv_segment_scan
//
// Drives two instances from shared stimulus:
//   dut_a : DIGITS=4, DIV=4, DEAD=1
//   dut_b : DIGITS=4, DIV=2, DEAD=0
// Expected outputs come from a reference model that derives slot, digit and
// phase from the number of clock edges since reset release, and keeps its own
// copy of the loaded display data.
// -----------------------------------------------------------------------------
module tb_drv_segment_scan;

   localparam int A_DIV  = 4;
   localparam int A_DEAD = 1;
   localparam int B_DIV  = 2;
   localparam int B_DEAD = 0;

   logic        clk;
   logic        rst_n;
   logic [15:0] val;
   logic        load;
   logic [3:0]  blank;

   logic [3:0]  a_val;
   logic [3:0]  a_anode;
   logic [2:0]  a_idx;
   logic [3:0]  b_val;
   logic [3:0]  b_anode;
   logic [2:0]  b_idx;

   int          n_vec;
   int          n_err;

   // Reference model state
   int          m_pos;
   logic [15:0] m_val;
   logic [3:0]  m_blk;

   drv_segment_scan #(.DIGITS(4), .DIV(A_DIV), .DEAD(A_DEAD)) dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_val   (val),
      .i_load  (load),
      .i_blank (blank),
      .o_val   (a_val),
      .o_anode (a_anode),
      .o_idx   (a_idx)
   );

   drv_segment_scan #(.DIGITS(4), .DIV(B_DIV), .DEAD(B_DEAD)) dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_val   (val),
      .i_load  (load),
      .i_blank (blank),
      .o_val   (b_val),
      .o_anode (b_anode),
      .o_idx   (b_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_blank(input int k, input logic [15:0] v, input logic [3:0] b);
      bit bl;
      bl = b[k] || (v[4*k +: 4] > 4'd9);
`ifdef DRV_SEGMENT_SCAN_LZB_EN
      if ((k > 0) && ((v >> (4*k)) == 16'h0))
         bl = 1'b1;
`endif
      return bl;
   endfunction

   // Expected outputs after the edge that follows scan position 'pos'.
   function automatic void model_out(input int pos, input int div, input int dead,
                                     input logic [15:0] v, input logic [3:0] b,
                                     output logic [3:0] anode, output logic [3:0] oval,
                                     output logic [2:0] oidx);
      int k;
      k     = (pos / div) % 4;
      oidx  = 3'(k);
      anode = 4'hF;
      oval  = 4'hF;
      if (((pos % div) >= dead) && !is_blank(k, v, b)) begin
         anode[k] = 1'b0;
         oval     = v[4*k +: 4];
      end
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_a_anode"}, 32'(a_anode), 32'hF);
      check({tag, "_a_val"},   32'(a_val),   32'hF);
      check({tag, "_a_idx"},   32'(a_idx),   32'h0);
      check({tag, "_b_anode"}, 32'(b_anode), 32'hF);
      check({tag, "_b_val"},   32'(b_val),   32'hF);
      check({tag, "_b_idx"},   32'(b_idx),   32'h0);
   endtask

   task automatic model_reset();
      m_pos = 0;
      m_val = 16'h0;
      m_blk = 4'hF;
   endtask

   // One clock edge: predict, advance the model, then compare #1 after the edge.
   task automatic step();
      logic [3:0] ea_an, ea_v, eb_an, eb_v;
      logic [2:0] ea_i, eb_i;
      model_out(m_pos, A_DIV, A_DEAD, m_val, m_blk, ea_an, ea_v, ea_i);
      model_out(m_pos, B_DIV, B_DEAD, m_val, m_blk, eb_an, eb_v, eb_i);
      if (load) begin
         m_val = val;
         m_blk = blank;
      end
      m_pos++;
      @(posedge clk);
      #1;
      check("a_anode", 32'(a_anode), 32'(ea_an));
      check("a_val",   32'(a_val),   32'(ea_v));
      check("a_idx",   32'(a_idx),   32'(ea_i));
      check("b_anode", 32'(b_anode), 32'(eb_an));
      check("b_val",   32'(b_val),   32'(eb_v));
      check("b_idx",   32'(b_idx),   32'(eb_i));
      check("b_onehot", 32'($countones(~b_anode) <= 1), 32'h1);
   endtask

   task automatic load_step(input logic [15:0] v, input logic [3:0] b);
      val   = v;
      blank = b;
      load  = 1'b1;
      step();
      load  = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++)
         step();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      load  = 1'b0;
      val   = 16'h0;
      blank = 4'h0;
      model_reset();

      // Reset state, held across an edge
      #12;
      check_reset_outputs("rst");
      rst_n = 1'b1;

      // Plain scan of 1234
      load_step(16'h1234, 4'h0);
      run(32);

      // Forced blank and out-of-range nibble
      load_step(16'h0A05, 4'b0100);
      run(16);

      // Leading-zero cases
      load_step(16'h0000, 4'h0);
      run(16);
      load_step(16'h0300, 4'h0);
      run(16);

      // Load coinciding with the last cycle of slot 0
      while ((m_pos % 16) != 3)
         step();
      load_step(16'h5555, 4'h0);
      run(20);

      // Asynchronous reset while digit 2 is lit on dut_a
      while ((m_pos % 16) != 11)
         step();
      check("pre_rst_a_anode", 32'(a_anode), 32'b1011);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      #10;
      rst_n = 1'b1;
      model_reset();
      run(20);
      load_step(16'h9087, 4'b0010);
      run(20);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [15:0] v;
         v = 16'h0;
         for (int k = 0; k < 4; k++)
            v[4*k +: 4] = 4'($urandom_range(0, 11));
         if ($urandom_range(0, 2) == 0)
            v = v >> (4 * $urandom_range(1, 4));
         val   = v;
         blank = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
         load  = ($urandom_range(0, 7) == 0);
         step();
         load  = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
